// File: rtl/acc_req_tagger.sv
// acc_req_tagger: tags core offload requests with free IDs and routes tagged responses back
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   core_q_*              core offload request in (wb=1 means a response is expected)
//   acc_q_*               registered, ID-tagged request out to the interconnect
//   acc_p_*               response in from the interconnect
//   core_p_*              registered response out to the core
//   outstanding_o         number of allocated IDs
//   err_o                 sticky protocol error
// Build option: define ACC_REQ_TAGGER_ID_CHECK_EN to drop responses whose ID is not
// allocated and flag them on err_o; otherwise responses are forwarded and err_o is 0.
package acc_pkg;
    localparam int AccAddrWidth = 32;
endpackage

module acc_req_tagger #(
    parameter int  NumIds       = 4,
    parameter int  AccAddrWidth = acc_pkg::AccAddrWidth,
    parameter int  DataWidth    = 32,
    localparam int IdWidth      = $clog2(NumIds)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    core_q_valid_i,
    input  logic [AccAddrWidth-1:0] core_q_addr_i,
    input  logic [DataWidth-1:0]    core_q_data_i,
    input  logic                    core_q_wb_i,
    output logic                    core_q_ready_o,
    output logic                    acc_q_valid_o,
    output logic [AccAddrWidth-1:0] acc_q_addr_o,
    output logic [DataWidth-1:0]    acc_q_data_o,
    output logic [IdWidth-1:0]      acc_q_id_o,
    input  logic                    acc_q_ready_i,
    input  logic                    acc_p_valid_i,
    input  logic [IdWidth-1:0]      acc_p_id_i,
    input  logic [DataWidth-1:0]    acc_p_data_i,
    output logic                    acc_p_ready_o,
    output logic                    core_p_valid_o,
    output logic [IdWidth-1:0]      core_p_id_o,
    output logic [DataWidth-1:0]    core_p_data_o,
    input  logic                    core_p_ready_i,
    output logic [IdWidth:0]        outstanding_o,
    output logic                    err_o
);
    logic [NumIds-1:0]       free_q, free_d;
    logic                    req_valid_q, req_valid_d;
    logic [AccAddrWidth-1:0] req_addr_q, req_addr_d;
    logic [DataWidth-1:0]    req_data_q, req_data_d;
    logic [IdWidth-1:0]      req_id_q, req_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [IdWidth-1:0]      rsp_id_q, rsp_id_d;
    logic [DataWidth-1:0]    rsp_data_q, rsp_data_d;
    logic [IdWidth:0]        outstanding_q, outstanding_d;
    logic [IdWidth:0]        free_cnt;
    logic [IdWidth-1:0]      sel_id;
    logic                    has_free, core_hs, alloc, rsp_hs, rsp_drop, rsp_load;

    // Selection looks at the registered bitmap only, so an ID released this cycle
    // cannot be handed out again before the next cycle.
    always_comb begin
        sel_id = '0;
        for (int i = NumIds - 1; i >= 0; i--)
            if (free_q[i]) sel_id = IdWidth'(i);
    end

    assign has_free       = |free_q;
    assign core_q_ready_o = (!req_valid_q || acc_q_ready_i) && (!core_q_wb_i || has_free);
    assign core_hs        = core_q_valid_i && core_q_ready_o;
    assign alloc          = core_hs && core_q_wb_i;
    assign acc_p_ready_o  = !rsp_valid_q || core_p_ready_i;
    assign rsp_hs         = acc_p_valid_i && acc_p_ready_o;
    assign rsp_load       = rsp_hs && !rsp_drop;

`ifdef ACC_REQ_TAGGER_ID_CHECK_EN
    logic err_q, err_d;
    assign rsp_drop = free_q[acc_p_id_i];
    assign err_o    = err_q;
    always_comb err_d = err_q || (rsp_hs && rsp_drop);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign rsp_drop = 1'b0;
    assign err_o    = 1'b0;
`endif

    always_comb begin
        free_d = free_q;
        if (rsp_hs) free_d[acc_p_id_i] = 1'b1;
        if (alloc)  free_d[sel_id]     = 1'b0;
        req_valid_d = core_hs || (req_valid_q && !acc_q_ready_i);
        req_addr_d  = core_hs ? core_q_addr_i : req_addr_q;
        req_data_d  = core_hs ? core_q_data_i : req_data_q;
        req_id_d    = core_hs ? (core_q_wb_i ? sel_id : '0) : req_id_q;
        rsp_valid_d = rsp_load || (rsp_valid_q && !core_p_ready_i);
        rsp_id_d    = rsp_load ? acc_p_id_i : rsp_id_q;
        rsp_data_d  = rsp_load ? acc_p_data_i : rsp_data_q;
        free_cnt = '0;
        for (int i = 0; i < NumIds; i++)
            free_cnt = free_cnt + (IdWidth+1)'(free_d[i]);
        outstanding_d = (IdWidth+1)'(NumIds) - free_cnt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            free_q        <= '1;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_id_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            outstanding_q <= '0;
        end else begin
            free_q        <= free_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            req_id_q      <= req_id_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign acc_q_valid_o  = req_valid_q;
    assign acc_q_addr_o   = req_addr_q;
    assign acc_q_data_o   = req_data_q;
    assign acc_q_id_o     = req_id_q;
    assign core_p_valid_o = rsp_valid_q;
    assign core_p_id_o    = rsp_id_q;
    assign core_p_data_o  = rsp_data_q;
    assign outstanding_o  = outstanding_q;
endmodule

// File: tb/tb_acc_req_tagger.sv
// tb_acc_req_tagger: directed and randomized scoreboard bench for acc_req_tagger
module tb_acc_req_tagger;
    localparam int N  = 4;
    localparam int AW = acc_pkg::AccAddrWidth;
    localparam int DW = 32;
    localparam int IW = $clog2(N);
`ifdef ACC_REQ_TAGGER_ID_CHECK_EN
    localparam bit IdChk = 1'b1;
`else
    localparam bit IdChk = 1'b0;
`endif

    logic          clk, rst_i;
    logic          core_q_valid_i, core_q_wb_i, core_q_ready_o;
    logic [AW-1:0] core_q_addr_i, acc_q_addr_o;
    logic [DW-1:0] core_q_data_i, acc_q_data_o, acc_p_data_i, core_p_data_o;
    logic          acc_q_valid_o, acc_q_ready_i, acc_p_valid_i, acc_p_ready_o;
    logic [IW-1:0] acc_q_id_o, acc_p_id_i, core_p_id_o;
    logic          core_p_valid_o, core_p_ready_i, err_o;
    logic [IW:0]   outstanding_o;

    acc_req_tagger #(.NumIds(N), .AccAddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_q_valid_i(core_q_valid_i), .core_q_addr_i(core_q_addr_i),
        .core_q_data_i(core_q_data_i), .core_q_wb_i(core_q_wb_i), .core_q_ready_o(core_q_ready_o),
        .acc_q_valid_o(acc_q_valid_o), .acc_q_addr_o(acc_q_addr_o), .acc_q_data_o(acc_q_data_o),
        .acc_q_id_o(acc_q_id_o), .acc_q_ready_i(acc_q_ready_i),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_id_i(acc_p_id_i), .acc_p_data_i(acc_p_data_i),
        .acc_p_ready_o(acc_p_ready_o),
        .core_p_valid_o(core_p_valid_o), .core_p_id_o(core_p_id_o), .core_p_data_o(core_p_data_o),
        .core_p_ready_i(core_p_ready_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          wb;
    } req_t;
    typedef struct {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } rsp_t;

    req_t   reqq[$];
    rsp_t   rspq[$];
    req_t   e, h;
    rsp_t   r, rh;
    bit [N-1:0] m_free, inflight;
    bit     m_err, req_full, rsp_full;
    int     lf;
    int     cand[$];
    int     n_cmp, n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wb);
        logic hs;
        core_q_valid_i = 1'b1;
        core_q_addr_i  = a;
        core_q_data_i  = d;
        core_q_wb_i    = wb;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            hs = core_q_ready_o;
            cyc();
        end
        core_q_valid_i = 1'b0;
        chk("send_handshake", hs, 1);
    endtask

    task automatic respond(input logic [IW-1:0] id, input logic [DW-1:0] d);
        logic hs;
        acc_p_valid_i = 1'b1;
        acc_p_id_i    = id;
        acc_p_data_i  = d;
        hs = 1'b0;
        for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge clk);
            hs = acc_p_ready_o;
            cyc();
        end
        acc_p_valid_i = 1'b0;
        chk("respond_handshake", hs, 1);
    endtask

    // Reference model and monitor: one step per cycle, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) begin
                chk("rst_acc_q_valid", acc_q_valid_o, 0);
                chk("rst_acc_q_addr", acc_q_addr_o, 0);
                chk("rst_acc_q_data", acc_q_data_o, 0);
                chk("rst_acc_q_id", acc_q_id_o, 0);
                chk("rst_core_p_valid", core_p_valid_o, 0);
                chk("rst_core_p_data", core_p_data_o, 0);
                chk("rst_outstanding", outstanding_o, 0);
                chk("rst_err", err_o, 0);
                reqq.delete();
                rspq.delete();
                m_free   = '1;
                inflight = '0;
                m_err    = 1'b0;
            end else begin
                req_full = reqq.size() != 0;
                rsp_full = rspq.size() != 0;
                lf = -1;
                for (int i = N - 1; i >= 0; i--) if (m_free[i]) lf = i;
                chk("acc_q_valid", acc_q_valid_o, req_full);
                if (acc_q_valid_o && req_full) begin
                    h = reqq[0];
                    chk("acc_q_addr", acc_q_addr_o, h.addr);
                    chk("acc_q_data", acc_q_data_o, h.data);
                    chk("acc_q_id", acc_q_id_o, h.id);
                    if (acc_q_ready_i) begin
                        void'(reqq.pop_front());
                        if (h.wb) inflight[h.id] = 1'b1;
                    end
                end
                chk("core_p_valid", core_p_valid_o, rsp_full);
                if (core_p_valid_o && rsp_full) begin
                    rh = rspq[0];
                    chk("core_p_id", core_p_id_o, rh.id);
                    chk("core_p_data", core_p_data_o, rh.data);
                    if (core_p_ready_i) void'(rspq.pop_front());
                end
                chk("outstanding", outstanding_o, N - $countones(m_free));
                chk("err", err_o, m_err);
                chk("core_q_ready", core_q_ready_o,
                    (!req_full || acc_q_ready_i) && (!core_q_wb_i || m_free != 0));
                chk("acc_p_ready", acc_p_ready_o, !rsp_full || core_p_ready_i);
                if (core_q_valid_i && core_q_ready_o) begin
                    e.addr = core_q_addr_i;
                    e.data = core_q_data_i;
                    e.wb   = core_q_wb_i;
                    e.id   = core_q_wb_i ? IW'(lf) : '0;
                    reqq.push_back(e);
                end
                if (acc_p_valid_i && acc_p_ready_o) begin
                    if (IdChk && m_free[acc_p_id_i]) m_err = 1'b1;
                    else begin
                        r.id   = acc_p_id_i;
                        r.data = acc_p_data_i;
                        rspq.push_back(r);
                    end
                    inflight[acc_p_id_i] = 1'b0;
                    m_free[acc_p_id_i]   = 1'b1;
                end
                if (core_q_valid_i && core_q_ready_o && core_q_wb_i && lf >= 0) m_free[lf] = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_i = 1'b1;
        core_q_valid_i = 0; core_q_addr_i = '0; core_q_data_i = '0; core_q_wb_i = 0;
        acc_q_ready_i = 0; acc_p_valid_i = 0; acc_p_id_i = '0; acc_p_data_i = '0;
        core_p_ready_i = 0;
        repeat (3) cyc();
        rst_i = 1'b0;
        acc_q_ready_i = 1'b1;
        core_p_ready_i = 1'b1;
        // four allocations, then the pool is exhausted
        for (int i = 0; i < 4; i++) send(AW'(32'h100 + i), DW'(i), 1'b1);
        core_q_valid_i = 1'b1; core_q_wb_i = 1'b1;
        core_q_addr_i = AW'(32'h200); core_q_data_i = 32'h55;
        @(negedge clk);
        chk("d_outstanding_full", outstanding_o, 4);
        chk("d_fifth_blocked", core_q_ready_o, 0);
        cyc();
        acc_p_valid_i = 1'b1; acc_p_id_i = 2; acc_p_data_i = 32'hDEADBEEF;
        @(negedge clk);
        chk("d_rsp_accept", acc_p_ready_o, 1);
        chk("d_no_reuse_same_cycle", core_q_ready_o, 0);
        cyc();
        acc_p_valid_i = 1'b0;
        @(negedge clk);
        chk("d_core_p_valid", core_p_valid_o, 1);
        chk("d_core_p_id", core_p_id_o, 2);
        chk("d_core_p_data", core_p_data_o, 32'hDEADBEEF);
        chk("d_stalled_ready", core_q_ready_o, 1);
        cyc();
        core_q_valid_i = 1'b0;
        @(negedge clk);
        chk("d_reuse_id2", acc_q_id_o, 2);
        cyc();
        // output register held while the interconnect stalls
        acc_q_ready_i = 1'b0;
        send(AW'(32'h300), 32'hA5A5, 1'b0);
        core_q_valid_i = 1'b1; core_q_wb_i = 1'b0;
        core_q_addr_i = AW'(32'h301); core_q_data_i = 32'h5A5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("d_stall_ready", core_q_ready_o, 0);
            chk("d_stall_valid", acc_q_valid_o, 1);
            chk("d_stall_addr", acc_q_addr_o, 32'h300);
            chk("d_stall_data", acc_q_data_o, 32'hA5A5);
            cyc();
        end
        acc_q_ready_i = 1'b1;
        @(negedge clk);
        chk("d_release_ready", core_q_ready_o, 1);
        cyc();
        core_q_valid_i = 1'b0;
        @(negedge clk);
        chk("d_next_addr", acc_q_addr_o, 32'h301);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        // simultaneous allocate and release
        send(AW'(32'h400), 32'h1, 1'b1);
        core_q_valid_i = 1'b1; core_q_wb_i = 1'b1;
        core_q_addr_i = AW'(32'h401); core_q_data_i = 32'h2;
        acc_p_valid_i = 1'b1; acc_p_id_i = 0; acc_p_data_i = 32'h1234;
        @(negedge clk);
        chk("d_both_core_ready", core_q_ready_o, 1);
        chk("d_both_acc_p_ready", acc_p_ready_o, 1);
        cyc();
        core_q_valid_i = 1'b0;
        acc_p_valid_i = 1'b0;
        @(negedge clk);
        chk("d_both_outstanding", outstanding_o, 1);
        chk("d_both_id", acc_q_id_o, 1);
        cyc();
        send(AW'(32'h402), 32'h3, 1'b1);
        @(negedge clk);
        chk("d_id0_reused", acc_q_id_o, 0);
        chk("d_two_outstanding", outstanding_o, 2);
        cyc();
        // reset with two outstanding and a pending request
        acc_q_ready_i = 1'b0;
        send(AW'(32'h500), 32'h7, 1'b0);
        @(negedge clk);
        chk("d_pending_valid", acc_q_valid_o, 1);
        chk("d_pending_outstanding", outstanding_o, 2);
        cyc();
        rst_i = 1'b1;
        #1;
        chk("d_async_valid", acc_q_valid_o, 0);
        chk("d_async_outstanding", outstanding_o, 0);
        chk("d_async_addr", acc_q_addr_o, 0);
        chk("d_async_core_p", core_p_valid_o, 0);
        cyc();
        rst_i = 1'b0;
        acc_q_ready_i = 1'b1;
        // response for an ID that was never allocated
        respond(3, 32'hCAFE);
        @(negedge clk);
        chk("d_bad_id_valid", core_p_valid_o, !IdChk);
        chk("d_bad_id_err", err_o, IdChk);
        chk("d_bad_id_outstanding", outstanding_o, 0);
        cyc();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        // randomized traffic
        repeat (3000) begin
            core_q_valid_i = 1'($urandom_range(0, 1));
            core_q_wb_i    = $urandom_range(0, 3) != 0;
            core_q_addr_i  = AW'($urandom);
            core_q_data_i  = DW'($urandom);
            acc_q_ready_i  = $urandom_range(0, 3) != 0;
            core_p_ready_i = $urandom_range(0, 3) != 0;
            cand.delete();
            for (int i = 0; i < N; i++) if (inflight[i]) cand.push_back(i);
            if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
                acc_p_valid_i = 1'b1;
                acc_p_id_i    = IW'(cand[$urandom_range(0, cand.size() - 1)]);
                acc_p_data_i  = DW'($urandom);
            end else acc_p_valid_i = 1'b0;
            cyc();
        end
        core_q_valid_i = 1'b0;
        acc_p_valid_i  = 1'b0;
        acc_q_ready_i  = 1'b1;
        core_p_ready_i = 1'b1;
        repeat (10) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_req_tagger.md
ACC_REQ_TAGGER -- requirements
Module: acc_req_tagger

Interface
REQ-001 SHALL have parameter NumIds, default 4, meaning number of concurrently outstanding offloads (power of two, 2..16).
REQ-002 SHALL have parameter AccAddrWidth, default acc_pkg::AccAddrWidth, meaning accelerator address width.
REQ-003 SHALL have parameter DataWidth, default 32, meaning operand/result width.
REQ-004 SHALL have localparam IdWidth = $clog2(NumIds).
REQ-005 SHALL have clk_i  input  1  the single clock, rising edge.
REQ-006 SHALL have rst_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have core_q_valid_i, core_q_addr_i, core_q_data_i, core_q_wb_i  input  1/AccAddrWidth/DataWidth/1  core offload request; wb=response expected.
REQ-008 SHALL have core_q_ready_o  output  1  request accepted.
REQ-009 SHALL have acc_q_valid_o, acc_q_addr_o, acc_q_data_o, acc_q_id_o  output  1/AccAddrWidth/DataWidth/IdWidth  tagged request to interconnect.
REQ-010 SHALL have acc_q_ready_i  input  1  interconnect accepts request.
REQ-011 SHALL have acc_p_valid_i, acc_p_id_i, acc_p_data_i  input  1/IdWidth/DataWidth  response from interconnect.
REQ-012 SHALL have acc_p_ready_o  output  1  response accepted.
REQ-013 SHALL have core_p_valid_o, core_p_id_o, core_p_data_o  output  1/IdWidth/DataWidth  response to core.
REQ-014 SHALL have core_p_ready_i  input  1  core accepts response.
REQ-015 SHALL have outstanding_o  output  IdWidth+1  count of allocated IDs; err_o  output  1  sticky protocol error.

Function
REQ-016 SHALL keep free bitmap free_q[NumIds]; allocate the lowest-index free ID.
REQ-017 Request stage SHALL be one output register (valid/addr/data/id); acc_q_* driven only from it.
REQ-018 core_q_ready_o SHALL be 1 iff (output register empty or acc_q_ready_i) and (core_q_wb_i=0 or a free ID exists).
REQ-019 On core handshake with wb=1 the selected ID SHALL clear in free_q same edge; wb=0 requests SHALL carry id 0 and allocate nothing.
REQ-020 acc_q_valid_o SHALL remain asserted with stable payload until acc_q_ready_i (no retraction).
REQ-021 Response stage SHALL be one output register; acc_p_ready_o = register empty or core_p_ready_i.
REQ-022 On response handshake acc_p_id_i SHALL be set free same edge; core_p_id_o/data_o carry the id/data unchanged, latency 1 cycle.
REQ-023 Same-cycle allocate and release SHALL both take effect; a released ID SHALL not be reallocated until the following cycle.
REQ-024 outstanding_o SHALL equal NumIds minus popcount(free_q), updated registered; simultaneous alloc+release leaves it unchanged.
REQ-025 All NumIds allocated: core_q_ready_o=0 for wb=1; wb=0 requests still pass.

Reset
REQ-026 rst_i SHALL immediately force free_q all-ones, outstanding_o=0, acc_q_valid_o=0, core_p_valid_o=0, err_o=0, payload registers 0.
REQ-027 Reset mid-transaction SHALL discard in-flight state; responses arriving after reset for pre-reset IDs follow REQ-029.

Configuration
REQ-028 Macro ACC_REQ_TAGGER_ID_CHECK_EN SHALL compile in response-ID checking.
REQ-029 With macro: response whose ID is already free SHALL be accepted and dropped (no core_p_valid_o), err_o set sticky until reset. Without macro: no check, response forwarded, err_o tied 0.

Verification
REQ-030 Reset, then 4 wb=1 requests with acc_q_ready_i=1 -> ids 0,1,2,3 issued, outstanding_o=4, 5th wb=1 request core_q_ready_o=0.
REQ-031 With 4 outstanding, response id 2 data 0xDEADBEEF -> next cycle core_p_valid_o=1, id 2, data 0xDEADBEEF; stalled request then gets id 2.
REQ-032 acc_q_ready_i=0 for 3 cycles -> acc_q_valid_o and payload stable, core_q_ready_o=0 until release.
REQ-033 Same cycle allocate (id 1) and response id 0 with 1 outstanding -> outstanding_o stays 1, id 0 free next cycle.
REQ-034 With ACC_REQ_TAGGER_ID_CHECK_EN, response id 3 never allocated -> dropped, err_o=1 held; without macro -> forwarded, err_o=0.
REQ-035 rst_i pulse with 2 outstanding and pending acc_q_valid_o -> all outputs at reset values same cycle, outstanding_o=0.
